seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (>=4).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset, sampled on rising clock edge.
REQ-004 SHALL have port a  input  WIDTH  operand A (dividend / multiplicand).
REQ-005 SHALL have port b  input  WIDTH  operand B (divisor / multiplier).
REQ-006 SHALL have port con  input  3  operation select: 000 AND, 001 OR, 010 SUB, 011 ADD, 100 SLT (signed), 101 XOR, 110 MULU, 111 DIVU.
REQ-007 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-008 SHALL have port c  output  WIDTH  result low word / quotient.
REQ-009 SHALL have port hi  output  WIDTH  product high word / remainder; 0 for single-cycle ops.
REQ-010 SHALL have port busy  output  1  iterative operation in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse: c/hi/flags valid.
REQ-012 SHALL have port zero  output  1  c == 0.
REQ-013 SHALL have port ovf  output  1  signed overflow (ADD/SUB only), else 0.
REQ-014 SHALL have port dz  output  1  divide by zero (DIVU only), else 0.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-016 SHALL accept start in IDLE or DONE (back-to-back), latching a, b, con that cycle (cycle T); start in RUN SHALL be ignored.
REQ-017 Single-cycle ops (con 000-101) SHALL go IDLE/DONE -> DONE, registering results at T+1: done=1 at T+1, busy never asserted.
REQ-018 ADD/SUB SHALL be modulo 2^WIDTH; ovf = signed overflow of the WIDTH-bit two's-complement operation.
REQ-019 SLT SHALL give c = 1 if signed a < signed b, else 0.
REQ-020 MULU SHALL be unsigned radix-2 shift-add, one bit per cycle: RUN for WIDTH cycles (busy=1 T+1..T+WIDTH), done=1 at T+WIDTH+1, {hi,c} = a*b (2*WIDTH-bit exact).
REQ-021 DIVU SHALL be unsigned restoring division, same timing as MULU; c = a / b, hi = a % b.
REQ-022 DIVU with b=0 SHALL skip RUN: done at T+1, c = all ones, hi = a, dz=1.
REQ-023 An iteration counter SHALL count WIDTH iterations; no wrap beyond WIDTH; a new op SHALL reload it.
REQ-024 c, hi, zero, ovf, dz SHALL hold their last values until the next done; intermediate RUN values SHALL NOT appear on c/hi.
REQ-025 Operand changes on a/b/con after T SHALL NOT affect the operation in flight.
REQ-026 start with reset=0 in the same cycle SHALL be ignored (reset wins).

Reset
REQ-027 reset=0 at a rising edge SHALL force state IDLE, c=0, hi=0, busy=0, done=0, zero=1, ovf=0, dz=0, counter=0.
REQ-028 reset asserted mid-RUN SHALL abort the operation with no done pulse; next start after release SHALL behave normally.

Verification (WIDTH=32)
REQ-029 a=9, b=5, con=011, start -> c=14, hi=0, done at T+1, busy=0 throughout; then con=010 -> c=4; then con=000 -> c=1, zero=0.
REQ-030 a=0x7FFFFFFF, b=1, con=011 -> c=0x80000000, ovf=1; a=5, b=5, con=010 -> c=0, zero=1, ovf=0.
REQ-031 a=0xFFFFFFFF, b=2, con=110 -> busy=1 for 32 cycles, done at T+33, hi=0x00000001, c=0xFFFFFFFE; start pulsed during RUN ignored.
REQ-032 a=100, b=7, con=111 -> done at T+33, c=14, hi=2, dz=0; then b=0 -> done at T+1, c=0xFFFFFFFF, hi=100, dz=1.
REQ-033 con=110 started, reset=0 at T+10 -> busy=0, done never pulses, outputs at reset values; start ADD 9+5 after release -> c=14 at T'+1.
REQ-034 start held high continuously with SLT a=-1, b=0 -> done every cycle, c=1 each time (back-to-back via DONE).

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle logic/arith ops and iterative
// unsigned multiply (radix-2 shift-add) and divide (restoring).
//
// Ports:
//   clock  - single clock, rising edge
//   reset  - synchronous active-low reset
//   a, b   - operands (dividend/multiplicand, divisor/multiplier)
//   con    - op select: 000 AND, 001 OR, 010 SUB, 011 ADD, 100 SLT,
//            101 XOR, 110 MULU, 111 DIVU
//   start  - request, accepted whenever no iterative op is running
//   c      - result low word / quotient
//   hi     - product high word / remainder (0 for single-cycle ops)
//   busy   - iterative op in progress
//   done   - one-cycle pulse, c/hi/flags updated
//   zero   - c == 0
//   ovf    - signed overflow of ADD/SUB
//   dz     - divide by zero
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       con,
  input  logic             start,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             ovf,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   c_q, c_d, hi_q, hi_d;
  logic               zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d;

  // Two's-complement overflow: operands (b already negated for SUB) share a
  // sign that differs from the sign of the sum.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        add_r, sub_r, alu_r;
  logic                    alu_ovf;

  assign a_s   = a;
  assign b_s   = b;
  assign add_r = a + b;
  assign sub_r = a - b;

  always_comb begin
    alu_r   = '0;
    alu_ovf = 1'b0;
    case (con)
      3'b000: alu_r = a & b;
      3'b001: alu_r = a | b;
      3'b010: begin
        alu_r   = sub_r;
        alu_ovf = add_ovf(a[WIDTH-1], ~b[WIDTH-1], sub_r[WIDTH-1]);
      end
      3'b011: begin
        alu_r   = add_r;
        alu_ovf = add_ovf(a[WIDTH-1], b[WIDTH-1], add_r[WIDTH-1]);
      end
      3'b100: alu_r = (a_s < b_s) ? WIDTH'(1) : '0;
      3'b101: alu_r = a ^ b;
      default: alu_r = '0;
    endcase
  end

  // One iteration step. work_q holds {upper, lower}: for MULU the partial
  // product over the remaining multiplier bits, for DIVU the partial
  // remainder over the dividend bits still to be shifted in (which become
  // quotient bits from the right).
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, step_next;

  assign mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_next  = work_q[0] ? {mul_sum, work_q[WIDTH-1:1]}
                               : {1'b0, work_q[2*WIDTH-1:1]};
  assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  // Borrow out means the trial subtraction failed: restore the shifted value.
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
  assign step_next = is_div_q ? div_next : mul_next;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    c_d      = c_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    case (state_q)
      RUN: begin
        work_d = step_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          c_d     = step_next[WIDTH-1:0];
          hi_d    = step_next[2*WIDTH-1:WIDTH];
          zero_d  = (step_next[WIDTH-1:0] == '0);
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          cnt_d = '0;
          if (con == 3'b110) begin
            state_d  = RUN;
            is_div_d = 1'b0;
            opnd_d   = a;
            work_d   = {{WIDTH{1'b0}}, b};
          end else if (con == 3'b111 && b != '0) begin
            state_d  = RUN;
            is_div_d = 1'b1;
            opnd_d   = b;
            work_d   = {{WIDTH{1'b0}}, a};
          end else if (con == 3'b111) begin
            state_d = DONE;
            c_d     = '1;
            hi_d    = a;
            zero_d  = 1'b0;
            ovf_d   = 1'b0;
            dz_d    = 1'b1;
          end else begin
            state_d = DONE;
            c_d     = alu_r;
            hi_d    = '0;
            zero_d  = (alu_r == '0);
            ovf_d   = alu_ovf;
            dz_d    = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      c_q     <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  // Working datapath registers are only meaningful while RUN, so no reset.
  always_ff @(posedge clock) begin
    work_q   <= work_d;
    opnd_q   <= opnd_d;
    is_div_q <= is_div_d;
  end

  assign c    = c_q;
  assign hi   = hi_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   con = '0;
  logic         start = 1'b0;
  logic [W-1:0] c, hi;
  logic         busy, done, zero, ovf, dz;

  seq_alu #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .a(a), .b(b), .con(con), .start(start),
    .c(c), .hi(hi), .busy(busy), .done(done), .zero(zero), .ovf(ovf), .dz(dz)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [W-1:0] c;
    logic [W-1:0] hi;
    logic         z, o, d;
    int           busy_n;
    int           due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   busy_run = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every done pulse with the oldest expected response.
  always @(negedge clock) begin
    if (!reset) begin
      busy_run = 0;
    end else if (done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", done, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.name, "_c"},    c,        mon_e.c);
        chk({mon_e.name, "_hi"},   hi,       mon_e.hi);
        chk({mon_e.name, "_zero"}, zero,     mon_e.z);
        chk({mon_e.name, "_ovf"},  ovf,      mon_e.o);
        chk({mon_e.name, "_dz"},   dz,       mon_e.d);
        chk({mon_e.name, "_busy"}, busy_run, mon_e.busy_n);
        chk({mon_e.name, "_time"}, cyc,      mon_e.due);
      end
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end
  end

  // Called at a negedge where start=1 is being presented; lat is the number
  // of RUN cycles before done.
  task automatic push_exp(input string name, input logic [W-1:0] ec, input logic [W-1:0] eh,
                          input logic ez, input logic eo, input logic ed, input int lat);
    exp_t e;
    e.name = name; e.c = ec; e.hi = eh; e.z = ez; e.o = eo; e.d = ed;
    e.busy_n = lat;
    e.due = cyc + 1 + lat;
    sbq.push_back(e);
  endtask

  task automatic issue(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [2:0] icon, input logic [W-1:0] ec, input logic [W-1:0] eh,
                       input logic ez, input logic eo, input logic ed);
    int lat;
    lat = ((icon == 3'b110) || (icon == 3'b111 && ib != '0)) ? W : 0;
    a = ia; b = ib; con = icon; start = 1'b1;
    push_exp(name, ec, eh, ez, eo, ed, lat);
    @(negedge clock);
    start = 1'b0;
    // Scramble operands so an in-flight op that re-reads them is caught.
    a = $urandom; b = $urandom; con = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (sbq.size() == 0) return;
      @(negedge clock);
    end
    chk("drain_timeout", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_c", c, 0);
    chk("rst_hi", hi, 0);
    chk("rst_zero", zero, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_dz", dz, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    @(negedge clock);

    issue("add",      32'd9, 32'd5, 3'b011, 32'd14, 0, 0, 0, 0); wait_idle();
    issue("sub",      32'd9, 32'd5, 3'b010, 32'd4,  0, 0, 0, 0); wait_idle();
    issue("and",      32'd9, 32'd5, 3'b000, 32'd1,  0, 0, 0, 0); wait_idle();
    issue("or",       32'd9, 32'd5, 3'b001, 32'd13, 0, 0, 0, 0); wait_idle();
    issue("xor",      32'd9, 32'd5, 3'b101, 32'd12, 0, 0, 0, 0); wait_idle();
    issue("add_ovf",  32'h7FFFFFFF, 32'd1, 3'b011, 32'h80000000, 0, 0, 1, 0); wait_idle();
    issue("sub_zero", 32'd5, 32'd5, 3'b010, 32'd0, 0, 1, 0, 0); wait_idle();
    issue("sub_ovf",  32'h80000000, 32'd1, 3'b010, 32'h7FFFFFFF, 0, 0, 1, 0); wait_idle();
    issue("slt_t",    32'hFFFFFFFF, 32'd0, 3'b100, 32'd1, 0, 0, 0, 0); wait_idle();
    issue("slt_f",    32'd0, 32'hFFFFFFFF, 3'b100, 32'd0, 0, 1, 0, 0); wait_idle();

    // MULU with a start pulse during RUN that must be ignored.
    issue("mulu", 32'hFFFFFFFF, 32'd2, 3'b110, 32'hFFFFFFFE, 32'h1, 0, 0, 0);
    repeat (5) @(negedge clock);
    a = 32'd1; b = 32'd1; con = 3'b011; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clock);
    chk("hold_c", c, 32'hFFFFFFFE);
    chk("hold_hi", hi, 32'h1);

    issue("mulu_zero", 32'h00010000, 32'h00010000, 3'b110, 32'h0, 32'h1, 1, 0, 0); wait_idle();
    issue("divu",      32'd100, 32'd7, 3'b111, 32'd14, 32'd2, 0, 0, 0); wait_idle();
    issue("divu_dz",   32'd100, 32'd0, 3'b111, 32'hFFFFFFFF, 32'd100, 0, 0, 1); wait_idle();
    issue("divu_big",  32'hFFFFFFFF, 32'd16, 3'b111, 32'h0FFFFFFF, 32'hF, 0, 0, 0); wait_idle();

    // Reset in the middle of a MULU: no done, outputs back to reset values.
    issue("mulu_abort", 32'd3, 32'd3, 3'b110, 32'd9, 0, 0, 0, 0);
    repeat (8) @(negedge clock);
    reset = 1'b0;
    sbq.delete();
    @(negedge clock);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_c", c, 0);
    chk("abort_hi", hi, 0);
    chk("abort_zero", zero, 1);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    issue("add_after_rst", 32'd9, 32'd5, 3'b011, 32'd14, 0, 0, 0, 0); wait_idle();

    // start together with reset must be ignored.
    reset = 1'b0; start = 1'b1; a = 32'd9; b = 32'd5; con = 3'b011;
    @(negedge clock);
    chk("rst_start_done", done, 0);
    chk("rst_start_c", c, 0);
    reset = 1'b1; start = 1'b0;
    @(negedge clock);
    chk("rst_start_done2", done, 0);

    // start held high: SLT completes every cycle via DONE.
    a = 32'hFFFFFFFF; b = 32'd0; con = 3'b100; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_exp("slt_b2b", 32'd1, 0, 0, 0, 0, 0);
      @(negedge clock);
    end
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
